// File: rtl/handshake_const_check_if.sv
// Elastic handshake bundle for handshake_const_check: one input channel
// carrying data tokens and one output channel carrying data, a match bit and
// the valid that doubles as the dataless ctrl token.
interface handshake_const_check_if #(
    parameter int DATA_WIDTH = 12
) ();
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_match;
    logic                  outs_valid;
    logic                  outs_ready;

    // Producer/environment side: drives input tokens and downstream ready.
    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_match, outs_valid
    );

    // Checker side: accepts input tokens and presents the FIFO head.
    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_match, outs_valid
    );
endinterface

// File: rtl/handshake_const_check.sv
// Consumer-side constant checker: accepts data tokens, compares each against
// EXPECTED, buffers token plus match bit in a small FIFO and emits them
// downstream. Keeps a sticky mismatch flag and a saturating token counter.
module handshake_const_check #(
    parameter int                    DATA_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] EXPECTED   = 12'h5AE,
    parameter int                    DEPTH      = 2,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    handshake_const_check_if.slave   bus,
    output logic                     mismatch,
    output logic [CNT_WIDTH-1:0]     token_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
    logic                  match_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic                  push;
    logic                  pop;

    // Handshake outputs from registered state only; everything forced idle
    // while reset is held so nothing leaks out during reset.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        bus.ins_ready  = 1'b0;
        bus.outs_valid = 1'b0;
        bus.outs       = '0;
        bus.outs_match = 1'b0;
        if (rst) begin
            bus.ins_ready  = (occupancy != OCC_W'(DEPTH));
            bus.outs_valid = (occupancy != '0);
            if (occupancy != '0) begin
                bus.outs       = data_mem[rd_ptr];
                bus.outs_match = match_mem[rd_ptr];
            end
        end
    end

    assign push = bus.ins_valid && bus.ins_ready;
    assign pop  = bus.outs_valid && bus.outs_ready;

    // Token storage: written at the write pointer on every accepted token.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy gates what is visible, so stale entries never escape.
        if (push) begin
            data_mem[wr_ptr]  <= bus.ins;
            match_mem[wr_ptr] <= (bus.ins == EXPECTED);
        end
    end

    // Pointers and occupancy; a full FIFO does not accept even on a pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Debug state: sticky mismatch flag and saturating accepted-token count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch    <= 1'b0;
            token_count <= '0;
        end else if (push) begin
            if (bus.ins != EXPECTED) mismatch <= 1'b1;
            if (token_count != '1)   token_count <= token_count + CNT_WIDTH'(1);
        end
    end
endmodule
